// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment display driver: scans NUM_DIGITS digits onto a shared
// segment bus with inter-digit blanking, brightness PWM, digit mask and frame tick.
module sevenseg_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DWELL_CYCLES   = 100000,
    parameter int unsigned BLANK_CYCLES   = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_DIGITS*7-1:0] digit_segments,
    input  logic [NUM_DIGITS-1:0]   digit_dp,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    input  logic [3:0]              brightness,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_tick
);

    localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned ON_W    = $clog2(DWELL_CYCLES + 1);

    localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t state, state_d;

    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [IDX_W-1:0]      idx, idx_d;
    logic                  latch;
    logic                  drive_on;
    logic                  tick_d;

    logic [6:0]            lat_seg;
    logic                  lat_dp;
    logic                  lat_mask;
    logic [ON_W-1:0]       lat_on;

    logic [NUM_DIGITS-1:0] sel;
    logic [NUM_DIGITS-1:0] anodes_d;
    logic [6:0]            segments_d;
    logic                  dp_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Pin values are derived from the current state and registered, so the pins
    // trail the state by one cycle; dropping enable forces them dark immediately.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        idx_d    = idx;
        latch    = 1'b0;
        drive_on = 1'b0;
        tick_d   = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                        latch   = 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    drive_on = lat_mask && (ON_W'(cnt) < lat_on);
                    if (cnt == DWELL_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        tick_d  = (idx == IDX_LAST);
                        idx_d   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            sel[i] = (32'(idx) == i);
        end
    end

    always_comb begin
        anodes_d   = AN_OFF;
        segments_d = SEG_OFF;
        dp_d       = DP_OFF;
        if (drive_on) begin
            anodes_d   = AN_OFF ^ sel;
            segments_d = SEG_OFF ^ lat_seg;
            dp_d       = DP_OFF ^ lat_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            lat_seg    <= '0;
            lat_dp     <= 1'b0;
            lat_mask   <= 1'b0;
            lat_on     <= '0;
            anodes     <= AN_OFF;
            segments   <= SEG_OFF;
            dp         <= DP_OFF;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            idx        <= idx_d;
            anodes     <= anodes_d;
            segments   <= segments_d;
            dp         <= dp_d;
            frame_tick <= tick_d;
            // Slot contents and on-time are frozen at DRIVE entry.
            if (latch) begin
                lat_seg  <= digit_segments[32'(idx) * 7 +: 7];
                lat_dp   <= digit_dp[idx];
                lat_mask <= digit_mask[idx];
                lat_on   <= ON_W'(((32'(brightness) + 32'd1) * DWELL_CYCLES) >> 4);
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: a frame-time arithmetic model checks two instances
// (active-low and active-high pins) every cycle, plus literal spot checks.
module tb_sevenseg_scan_driver;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int BL    = 2;
    localparam int SLOT  = BL + DW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [27:0] digit_segments;
    logic [3:0]  digit_dp;
    logic [3:0]  digit_mask;
    logic [3:0]  brightness;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;
    logic        tick_a, tick_b;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;
    int cur = 0;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(
        .NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut_low (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .digit_segments(digit_segments), .digit_dp(digit_dp),
        .digit_mask(digit_mask), .brightness(brightness),
        .segments(seg_a), .dp(dp_a), .anodes(an_a), .frame_tick(tick_a)
    );

    sevenseg_scan_driver #(
        .NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut_high (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .digit_segments(digit_segments), .digit_dp(digit_dp),
        .digit_mask(digit_mask), .brightness(brightness),
        .segments(seg_b), .dp(dp_b), .anodes(an_b), .frame_tick(tick_b)
    );

    // Model: sc = cycles since scanning started; slot/digit follow by division.
    int         sc = -1;
    int         m_d, m_r, m_on = 0;
    logic [6:0] m_seg = '0;
    logic       m_dp = 1'b0, m_mask = 1'b0;
    logic [3:0] e_sel = '0;
    logic [6:0] e_seg = '0;
    logic       e_dp = 1'b0, e_tick = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc = -1;
            e_sel = '0; e_seg = '0; e_dp = 1'b0; e_tick = 1'b0;
        end else begin
            e_sel = '0; e_seg = '0; e_dp = 1'b0; e_tick = 1'b0;
            if (!enable) begin
                sc = -1;
            end else if (sc < 0) begin
                sc = 0;
            end else begin
                m_d = (sc / SLOT) % N;
                m_r = sc % SLOT;
                if (m_r >= BL && m_mask && (m_r - BL) < m_on) begin
                    e_sel[m_d] = 1'b1;
                    e_seg = m_seg;
                    e_dp = m_dp;
                end
                e_tick = (m_d == N - 1) && (m_r == SLOT - 1);
                sc = sc + 1;
                if (sc % SLOT == BL) begin
                    m_d = (sc / SLOT) % N;
                    m_seg = digit_segments[m_d*7 +: 7];
                    m_dp = digit_dp[m_d];
                    m_mask = digit_mask[m_d];
                    m_on = ((int'(brightness) + 1) * DW) / 16;
                end
            end
        end
    end

    logic [12:0] exp_a, exp_b, act_a, act_b;

    always @(negedge clk) begin
        if (checking) begin
            exp_a = {~e_sel, ~e_seg, ~e_dp, e_tick};
            exp_b = {e_sel, e_seg, e_dp, e_tick};
            act_a = {an_a, seg_a, dp_a, tick_a};
            act_b = {an_b, seg_b, dp_b, tick_b};
            checks++;
            if (act_a !== exp_a) begin
                errors++;
                $display("FAIL pins_lowpol t=%0t actual=%h required=%h", $time, act_a, exp_a);
            end
            checks++;
            if (act_b !== exp_b) begin
                errors++;
                $display("FAIL pins_highpol t=%0t actual=%h required=%h", $time, act_b, exp_b);
            end
            checks++;
            if ($countones(~an_a) > 1 || $countones(an_b) > 1) begin
                errors++;
                $display("FAIL one_anode t=%0t actual=%b/%b required=at most one active", $time, an_a, an_b);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cur, act, exp);
        end
    endtask

    task automatic go_to(input int k);
        repeat (k - cur) @(negedge clk);
        cur = k;
    endtask

    initial begin
        rst_n = 1'b1;
        enable = 1'b0;
        digit_segments = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        digit_dp = 4'b0101;
        digit_mask = 4'hF;
        brightness = 4'd15;
        #2 rst_n = 1'b0;
        #1 checking = 1'b1;
        #2;
        chk("rst_an_low", 32'(an_a), 32'h0F);
        chk("rst_seg_low", 32'(seg_a), 32'h7F);
        chk("rst_dp_low", 32'(dp_a), 32'h1);
        chk("rst_an_high", 32'(an_b), 32'h0);
        chk("rst_tick", 32'(tick_a), 32'h0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cur = -1;

        go_to(2);   chk("blank_c2", 32'(an_a), 32'hF);
        go_to(3);   chk("d0_an_low", 32'(an_a), 32'hE);
                    chk("d0_seg_low", 32'(seg_a), 32'h40);
                    chk("d0_dp_low", 32'(dp_a), 32'h0);
                    chk("d0_an_high", 32'(an_b), 32'h1);
                    chk("d0_seg_high", 32'(seg_b), 32'h3F);
        go_to(18);  chk("d0_last", 32'(an_a), 32'hE);
        go_to(19);  chk("blank_c19", 32'(an_a), 32'hF);
        go_to(21);  chk("d1_an", 32'(an_a), 32'hD);
                    chk("d1_seg", 32'(seg_a), 32'h79);
        go_to(71);  chk("tick_c71", 32'(tick_a), 32'h0);
        go_to(72);  chk("tick_c72", 32'(tick_a), 32'h1);
        go_to(144); chk("tick_c144", 32'(tick_a), 32'h1);
        brightness = 4'd7;
        go_to(154); chk("b7_on_last", 32'(an_a), 32'hE);
        go_to(155); chk("b7_off", 32'(an_a), 32'hF);
        go_to(216); chk("tick_c216", 32'(tick_b), 32'h1);
        brightness = 4'd0;
        go_to(219); chk("b0_on", 32'(an_a), 32'hE);
        go_to(220); chk("b0_off", 32'(an_a), 32'hF);
        go_to(288);
        brightness = 4'd15;
        digit_mask = 4'b1010;
        go_to(291); chk("mask_d0_dark", 32'(an_a), 32'hF);
        go_to(309); chk("mask_d1_on", 32'(an_a), 32'hD);
        go_to(324); chk("mask_d1_last", 32'(an_a), 32'hD);
        go_to(359); chk("mask_tick_c359", 32'(tick_a), 32'h0);
        go_to(360); chk("mask_tick_c360", 32'(tick_a), 32'h1);
        go_to(385);
        digit_segments[13:7] = 7'h7F;
        go_to(390); chk("mid_change_held", 32'(seg_a), 32'h79);
        go_to(455); chk("next_slot_new", 32'(seg_a), 32'h00);
        go_to(500);
        digit_mask = 4'hF;
        go_to(546); chk("d2_before_drop", 32'(an_a), 32'hB);
        enable = 1'b0;
        go_to(547); chk("drop_an", 32'(an_a), 32'hF);
                    chk("drop_seg", 32'(seg_a), 32'h7F);
        go_to(550);
        enable = 1'b1;
        go_to(553); chk("reen_blank", 32'(an_a), 32'hF);
        go_to(554); chk("reen_d0", 32'(an_a), 32'hE);
        go_to(560); chk("pre_reset", 32'(an_a), 32'hE);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an_low", 32'(an_a), 32'hF);
        chk("async_seg_low", 32'(seg_a), 32'h7F);
        chk("async_dp_low", 32'(dp_a), 32'h1);
        chk("async_an_high", 32'(an_b), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cur = -1;
        go_to(3);   chk("post_reset_d0", 32'(an_a), 32'hE);
        go_to(150);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
